// File: rtl/switch_box_config_chain.sv
// switch_box_config_chain: serial configuration loader for two-track switch box
// elements. Bits shift into a chain register and a commit moves the data field
// into a shadow register that drives the transmission-gate control buses.
// Optional build macro CFG_PARITY_EN adds a trailing even-parity bit per load
// and rejects commits whose parity does not check.

// Per-element shadow slice: holds one element's gate controls between commits.
module switch_box_cfg_shadow #(
    parameter int BITS_PER_ELEM = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [BITS_PER_ELEM-1:0] d,
    output logic [BITS_PER_ELEM-1:0] q
);
    // Reset opens every gate; only a successful commit updates the slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q <= '0;
        else if (load) q <= d;
    end
endmodule

module switch_box_config_chain #(
    parameter int NUM_ELEMS     = 4,
    parameter int BITS_PER_ELEM = 12,
    localparam int TOTAL        = NUM_ELEMS * BITS_PER_ELEM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_in,
    input  logic             cfg_en,
    input  logic             cfg_commit,
    output logic             cfg_out,
    output logic [TOTAL-1:0] c_out,
    output logic             cfg_done,
    output logic             cfg_err
);
`ifdef CFG_PARITY_EN
    localparam int W = TOTAL + 1;
`else
    localparam int W = TOTAL;
`endif
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    count, count_nx;
    logic [W-1:0]     sr;
    logic [TOTAL-1:0] data;
    logic             par_ok;
    logic             load, set_err, clr_err, done_nx;

`ifdef CFG_PARITY_EN
    // Last bit shifted is the parity bit; the whole register must XOR to 0.
    assign data   = sr[W-1:1];
    assign par_ok = ~(^sr);
`else
    assign data   = sr;
    assign par_ok = 1'b1;
`endif

    // Downstream chain sees the oldest bit, W shifts after it entered.
    assign cfg_out = sr[W-1];

    // State and bit-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    // Next state, count and commit decisions; commit in FULL uses pre-shift sr.
    always_comb begin
        state_nx = state;
        count_nx = count;
        load     = 1'b0;
        set_err  = 1'b0;
        clr_err  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_en) begin
                    count_nx = CW'(1);
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cfg_commit) set_err = 1'b1;
                if (cfg_en) begin
                    if (count == CW'(W - 1)) begin
                        count_nx = CW'(W);
                        state_nx = FULL;
                    end else begin
                        count_nx = count + CW'(1);
                    end
                end
            end
            FULL: begin
                if (cfg_commit) begin
                    if (par_ok) begin
                        load    = 1'b1;
                        done_nx = 1'b1;
                        clr_err = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                    count_nx = cfg_en ? CW'(1) : '0;
                    state_nx = cfg_en ? SHIFT : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end

    // Serial shift register; shifting is independent of commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sr <= '0;
        else if (cfg_en) sr <= {sr[W-2:0], cfg_in};
    end

    // Done pulse lasts one cycle; error is sticky until a good commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= done_nx;
            if (set_err)      cfg_err <= 1'b1;
            else if (clr_err) cfg_err <= 1'b0;
        end
    end

    // One shadow slice per element; all load together so no partial config.
    for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_elem
        switch_box_cfg_shadow #(.BITS_PER_ELEM(BITS_PER_ELEM)) u_shadow (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .d     (data[k*BITS_PER_ELEM +: BITS_PER_ELEM]),
            .q     (c_out[k*BITS_PER_ELEM +: BITS_PER_ELEM])
        );
    end
endmodule

// File: tb/tb_switch_box_config_chain.sv
// Bench for switch_box_config_chain with one element (12 data bits).
// A bit-history model predicts every output; directed sequences add literal
// expectations. Build with CFG_PARITY_EN to cover the parity variant.
module tb_switch_box_config_chain;
    localparam int TOTAL = 12;
`ifdef CFG_PARITY_EN
    localparam int W = TOTAL + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int W = TOTAL;
    localparam bit PAR = 1'b0;
`endif

    logic             clk, rst_n, cfg_in, cfg_en, cfg_commit;
    logic             cfg_out, cfg_done, cfg_err;
    logic [TOTAL-1:0] c_out;

    switch_box_config_chain #(.NUM_ELEMS(1), .BITS_PER_ELEM(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_in     (cfg_in),
        .cfg_en     (cfg_en),
        .cfg_commit (cfg_commit),
        .cfg_out    (cfg_out),
        .c_out      (c_out),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Model: the last W bits shifted (oldest first), bits since last commit,
    // and the committed word with its status flags.
    bit               q[$];
    int               n;
    logic [TOTAL-1:0] m_c;
    bit               m_done, m_err;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < W; i++) q.push_back(1'b0);
        n = 0; m_c = '0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input bit en, input bit din, input bit commit);
        logic [TOTAL-1:0] d;
        bit               x;
        m_done = 0;
        if (commit) begin
            if (n >= W) begin
                x = 0;
                for (int i = 0; i < W; i++) x ^= q[i];
                for (int i = 0; i < TOTAL; i++) d[TOTAL-1-i] = q[i];
                if (PAR && x) m_err = 1;
                else begin m_c = d; m_done = 1; m_err = 0; end
                n = 0;
            end else if (n > 0) begin
                m_err = 1;
            end
        end
        if (en) begin
            q.push_back(din);
            void'(q.pop_front());
            if (n < W) n++;
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("mdl_c_out", 32'(c_out), 32'(m_c));
            check("mdl_done", 32'(cfg_done), 32'(m_done));
            check("mdl_err", 32'(cfg_err), 32'(m_err));
            check("mdl_cfg_out", 32'(cfg_out), 32'(q[0]));
        end
    end

    // One clock: inputs held across the edge, returns just after the falling edge.
    task automatic cyc(input bit en, input bit din, input bit commit);
        cfg_en = en; cfg_in = din; cfg_commit = commit;
        @(posedge clk);
        model_step(en, din, commit);
        @(negedge clk);
        #1;
        cfg_en = 0; cfg_in = 0; cfg_commit = 0;
    endtask

    task automatic shift_bits(input logic [TOTAL-1:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) cyc(1'b1, v[i], 1'b0);
    endtask

    task automatic shift_par(input logic [TOTAL-1:0] v, input bit flip);
        if (PAR) cyc(1'b1, (^v) ^ flip, 1'b0);
    endtask

    task automatic load_word(input logic [TOTAL-1:0] v);
        shift_bits(v, TOTAL-1, 0);
        shift_par(v, 1'b0);
    endtask

    logic [TOTAL-1:0] w1;

    initial begin
        rst_n = 0; cfg_en = 0; cfg_in = 0; cfg_commit = 0;
        model_reset();
        #3;
        check("rst_c_out", 32'(c_out), 32'h000);
        check("rst_done", 32'(cfg_done), 0);
        check("rst_err", 32'(cfg_err), 0);
        check("rst_cfg_out", 32'(cfg_out), 0);
        @(negedge clk); #1;
        rst_n = 1;

        // Basic load and one-cycle done pulse.
        load_word(12'hA5C);
        cyc(0, 0, 1);
        check("load_c_out", 32'(c_out), 32'hA5C);
        check("load_done", 32'(cfg_done), 1);
        cyc(0, 0, 0);
        check("load_done_low", 32'(cfg_done), 0);
        cyc(0, 0, 1);  // commit while idle: ignored
        check("idle_commit_err", 32'(cfg_err), 0);
        check("idle_commit_c", 32'(c_out), 32'hA5C);

        // Early commit keeps the old word and flags an error.
        shift_bits(12'h3C6, 11, 5);
        cyc(0, 0, 1);
        check("early_c_out", 32'(c_out), 32'hA5C);
        check("early_err", 32'(cfg_err), 1);
        shift_bits(12'h3C6, 4, 0);
        shift_par(12'h3C6, 1'b0);
        cyc(0, 0, 1);
        check("late_c_out", 32'(c_out), 32'h3C6);
        check("late_err", 32'(cfg_err), 0);

        // Chaining: first word appears on cfg_out while the second shifts in.
        w1 = 12'h3F0;
        load_word(w1);
        for (int i = TOTAL-1; i >= 0; i--) begin
            check("chain_cfg_out", 32'(cfg_out), 32'(w1[i]));
            cyc(1, w1[i] ^ 1'b0 ? 1'b0 : 1'b0, 0);
        end
        // That loop shifted zeros; reload cleanly with the intended pair.
        load_word(12'h3F0);
        w1 = 12'hA5C;
        for (int i = TOTAL-1; i >= 0; i--) begin
            check("chain2_cfg_out", 32'(cfg_out), 32'(12'h3F0 >> i) & 1);
            cyc(1, w1[i], 0);
        end
        shift_par(12'hA5C, 1'b0);
        cyc(0, 0, 1);
        check("chain_c_out", 32'(c_out), 32'hA5C);

        // Commit and shift together in FULL: new load already has one bit.
        load_word(12'h9C3 ^ 12'h0F0);
        w1 = 12'h9C3;
        cyc(1, w1[11], 1);
        check("sim_c_out", 32'(c_out), 32'hA5C ^ 32'h000 ^ 32'(12'h9C3 ^ 12'h0F0) ^ 32'hA5C);
        check("sim_done", 32'(cfg_done), 1);
        shift_bits(w1, 10, 0);
        shift_par(w1, 1'b0);
        cyc(0, 0, 1);
        check("sim_next_c_out", 32'(c_out), 32'h9C3);
        check("sim_next_err", 32'(cfg_err), 0);

        // Parity rejection (only meaningful when parity is built in).
        if (PAR) begin
            load_word(12'hA5C);
            cyc(0, 0, 1);
            check("par_ok_c_out", 32'(c_out), 32'hA5C);
            shift_bits(12'h5A3, 11, 0);
            shift_par(12'h5A3, 1'b1);
            cyc(0, 0, 1);
            check("par_bad_c_out", 32'(c_out), 32'hA5C);
            check("par_bad_err", 32'(cfg_err), 1);
            check("par_bad_done", 32'(cfg_done), 0);
        end

        // Asynchronous reset between clock edges clears everything at once.
        load_word(12'hFFF);
        rst_n = 0;
        model_reset();
        #2;
        check("arst_c_out", 32'(c_out), 0);
        check("arst_done", 32'(cfg_done), 0);
        check("arst_err", 32'(cfg_err), 0);
        check("arst_cfg_out", 32'(cfg_out), 0);
        #1;
        rst_n = 1;
        cyc(0, 0, 1);  // idle after reset: no error, no change
        check("post_rst_err", 32'(cfg_err), 0);
        check("post_rst_c_out", 32'(c_out), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
